// File: rtl/power_manager.sv
// power_manager: saturating battery integrator, hysteretic power-grant FSM and brownout latch.
module power_manager #(
  parameter int W           = 12,
  parameter int CAP_MAX     = 4095,
  parameter int INIT_CHARGE = 1024,
  parameter int DRAIN_AIR   = 2,
  parameter int DRAIN_THR   = 10,
  parameter int LOW_TH      = 512,
  parameter int CRIT_TH     = 128,
  parameter int HYST        = 64,
  parameter int CRIT_LIMIT  = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   sun_power,
  input  logic         charge_en,
  input  logic         air_req,
  input  logic         thr_req,
  output logic         air_en,
  output logic         thr_en,
  output logic [W-1:0] charge,
  output logic [1:0]   state,
  output logic         alert,
  output logic         shutdown
);
  localparam int S = W + 2;
  localparam logic [1:0] OFF = 2'b00, NORM = 2'b01, LOW = 2'b10, CRIT = 2'b11;
  localparam logic [W-1:0] LOW_DN = W'(LOW_TH);
  localparam logic [W-1:0] LOW_UP = W'(LOW_TH + HYST);
  localparam logic [W-1:0] CRIT_DN = W'(CRIT_TH);
  localparam logic [W-1:0] CRIT_UP = W'(CRIT_TH + HYST);
  localparam logic [W-1:0] AIR_W = W'(DRAIN_AIR);
  localparam logic [W-1:0] CAP_W = W'(CAP_MAX);
  localparam logic [S-1:0] AIR_S = S'(DRAIN_AIR);
  localparam logic [S-1:0] THR_S = S'(DRAIN_THR);
  localparam logic signed [S-1:0] CAP_S = S'(CAP_MAX);
  localparam logic [4:0] LIMIT = 5'(CRIT_LIMIT);
  logic [1:0]          state_next;
  logic [W-1:0]        charge_next;
  logic signed [S-1:0] sum;
  logic [4:0]          cnt, cnt_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= OFF;
      charge   <= W'(INIT_CHARGE);
      cnt      <= '0;
      shutdown <= 1'b0;
    end else begin
      state    <= state_next;
      charge   <= charge_next;
      cnt      <= cnt_next;
      shutdown <= shutdown | (cnt_next == LIMIT);
    end
  always_comb begin
    state_next = state;
    case (state)
      OFF:  state_next = charge >= LOW_UP ? NORM : charge >= CRIT_DN ? LOW : CRIT;
      NORM: state_next = charge < CRIT_DN ? CRIT : charge < LOW_DN ? LOW : NORM;
      LOW:  state_next = charge < CRIT_DN ? CRIT : charge >= LOW_UP ? NORM : LOW;
      CRIT: state_next = charge >= CRIT_UP ? LOW : CRIT;
    endcase
  end
  always_comb begin
    sum = S'(charge) + S'(charge_en ? sun_power : 8'd0) - (air_en ? AIR_S : '0) - (thr_en ? THR_S : '0);
    charge_next = sum[S-1] ? '0 : sum > CAP_S ? CAP_W : sum[W-1:0];
    cnt_next = state != CRIT ? '0 : cnt == LIMIT ? cnt : cnt + 5'd1;
  end
  always_comb begin
    air_en = !shutdown && air_req && (state == NORM || state == LOW || (state == CRIT && charge >= AIR_W));
    thr_en = !shutdown && thr_req && state == NORM;
    alert  = state == CRIT;
  end
`ifdef POWER_MANAGER_LOG_EN
  always @(posedge clk)
    if (!rst) begin
      if (state_next != state)
        $display("power %b %b %d", state, state_next, charge);
      if (!shutdown && cnt_next == LIMIT)
        $display("power shutdown");
    end
`endif
endmodule

// File: tb/tb_power_manager.sv
// tb_power_manager: directed vectors with hand-computed expectations for power_manager.
module tb_power_manager;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  sun_power = 8'd0;
   logic        charge_en = 1'b0;
   logic        air_req = 1'b1;
   logic        thr_req = 1'b1;
   logic        air_en, thr_en, alert, shutdown;
   logic [11:0] charge;
   logic [1:0]  state;
   int          tests = 0;
   int          fails = 0;

   power_manager dut (
      .clk(clk), .rst(rst), .sun_power(sun_power), .charge_en(charge_en),
      .air_req(air_req), .thr_req(thr_req), .air_en(air_en), .thr_en(thr_en),
      .charge(charge), .state(state), .alert(alert), .shutdown(shutdown)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drain from a fresh reset with both loads on: NORM at 1024 down to LOW at 496.
   task automatic drain_to_low();
      step(1);
      check("rel_state", state, 1);
      check("rel_charge", charge, 1024);
      check("rel_air", air_en, 1);
      check("rel_thr", thr_en, 1);
      step(1);
      check("norm_drain12", charge, 1012);
      step(41);
      check("norm_520", charge, 520);
      step(1);
      check("norm_508_charge", charge, 508);
      check("norm_508_state", state, 1);
      step(1);
      check("low_state", state, 2);
      check("low_charge", charge, 496);
      check("low_thr_off", thr_en, 0);
      check("low_air_on", air_en, 1);
      step(1);
      check("low_drain2", charge, 494);
   endtask

   initial begin
      step(2);
      check("rst_charge", charge, 1024);
      check("rst_state", state, 0);
      check("rst_air", air_en, 0);
      check("rst_thr", thr_en, 0);
      check("rst_alert", alert, 0);
      check("rst_shutdown", shutdown, 0);
      rst = 1'b0;
      drain_to_low();
      // LOW hysteresis on the way up
      air_req = 1'b0; thr_req = 1'b0; charge_en = 1'b1; sun_power = 8'd8;
      step(10);
      check("hyst_574", charge, 574);
      check("hyst_574_state", state, 2);
      step(1);
      check("hyst_582", charge, 582);
      check("hyst_582_state", state, 2);
      step(1);
      check("hyst_norm", state, 1);
      check("hyst_590", charge, 590);
      // saturation at CAP_MAX
      sun_power = 8'd200;
      step(17);
      check("sat_3990", charge, 3990);
      step(1);
      check("sat_cap", charge, 4095);
      step(2);
      check("sat_hold", charge, 4095);
      air_req = 1'b1; thr_req = 1'b1; sun_power = 8'd5;
      step(1);
      check("sat_net", charge, 4088);
      // asynchronous reset mid-drain
      charge_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_charge", charge, 1024);
      check("arst_state", state, 0);
      check("arst_air", air_en, 0);
      check("arst_thr", thr_en, 0);
      step(1);
      rst = 1'b0;
      drain_to_low();
      thr_req = 1'b0;
      step(184);
      check("crit_126", charge, 126);
      check("crit_126_state", state, 2);
      step(1);
      check("crit_state", state, 3);
      check("crit_alert", alert, 1);
      check("crit_charge", charge, 124);
      check("crit_air", air_en, 1);
      step(15);
      check("crit_pre_sd", shutdown, 0);
      check("crit_94", charge, 94);
      step(1);
      check("sd_set", shutdown, 1);
      check("sd_air", air_en, 0);
      check("sd_charge", charge, 92);
      step(1);
      check("sd_hold_charge", charge, 92);
      // recovery keeps the FSM running but shutdown sticks
      charge_en = 1'b1; sun_power = 8'd100;
      step(1);
      check("rec_192", charge, 192);
      check("rec_192_state", state, 3);
      step(1);
      check("rec_low", state, 2);
      check("rec_sd", shutdown, 1);
      check("rec_air", air_en, 0);
      step(1);
      check("rec_392", charge, 392);
      rst = 1'b1;
      #1;
      check("sd_clear", shutdown, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
